// File: rtl/stack_mem_ctrl.sv
// Operand-stack / local-variable memory initiator for the JVM datapath.
// Runs one PUSH/POP/LOAD/STORE at a time over the start/ready/rwn handshake.
module stack_mem_ctrl #(
    parameter int unsigned STACK_BASE  = 192,
    parameter int unsigned STACK_LIMIT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] sp,
    output logic        mem_start,
    output logic        mem_rwn,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic        mem_ready,
    input  logic [31:0] mem_data_out
);

    localparam logic [31:0] LP_BASE  = 32'(STACK_BASE);
    localparam logic [31:0] LP_LIMIT = 32'(STACK_LIMIT);
    localparam logic [31:0] LP_WORD  = 32'd4;

    localparam logic [1:0] CMD_PUSH  = 2'b00;
    localparam logic [1:0] CMD_POP   = 2'b01;
    localparam logic [1:0] CMD_LOAD  = 2'b10;
    localparam logic [1:0] CMD_STORE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t      r_state, w_state;
    logic [1:0]  r_cmd, w_cmd;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic        r_err, w_err;
    logic [31:0] r_rdata, w_rdata;
    logic [31:0] r_sp, w_sp;
    logic        r_mem_start, w_mem_start;
    logic        r_mem_rwn, w_mem_rwn;
    logic [31:0] r_mem_address, w_mem_address;
    logic [31:0] r_mem_data_in, w_mem_data_in;

    // State and all outputs registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cmd         <= CMD_PUSH;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_rdata       <= 32'd0;
            r_sp          <= LP_BASE;
            r_mem_start   <= 1'b0;
            r_mem_rwn     <= 1'b1;
            r_mem_address <= 32'd0;
            r_mem_data_in <= 32'd0;
        end else begin
            r_state       <= w_state;
            r_cmd         <= w_cmd;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_err         <= w_err;
            r_rdata       <= w_rdata;
            r_sp          <= w_sp;
            r_mem_start   <= w_mem_start;
            r_mem_rwn     <= w_mem_rwn;
            r_mem_address <= w_mem_address;
            r_mem_data_in <= w_mem_data_in;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_cmd         = r_cmd;
        w_busy        = r_busy;
        w_done        = 1'b0;
        w_err         = r_err;
        w_rdata       = r_rdata;
        w_sp          = r_sp;
        w_mem_start   = r_mem_start;
        w_mem_rwn     = r_mem_rwn;
        w_mem_address = r_mem_address;
        w_mem_data_in = r_mem_data_in;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_cmd  = cmd;
                    w_busy = 1'b1;
                    // Bound violations complete with err and never touch memory.
                    if ((cmd == CMD_PUSH && r_sp == LP_LIMIT) ||
                        (cmd == CMD_POP  && r_sp == LP_BASE)) begin
                        w_err   = 1'b1;
                        w_state = S_FIN;
                    end else begin
                        w_mem_start = 1'b1;
                        w_state     = S_REQ;
                        case (cmd)
                            CMD_PUSH: begin
                                w_mem_address = r_sp;
                                w_mem_rwn     = 1'b0;
                                w_mem_data_in = cmd_wdata;
                            end
                            CMD_POP: begin
                                w_mem_address = r_sp - LP_WORD;
                                w_mem_rwn     = 1'b1;
                            end
                            CMD_LOAD: begin
                                w_mem_address = cmd_addr;
                                w_mem_rwn     = 1'b1;
                            end
                            default: begin
                                w_mem_address = cmd_addr;
                                w_mem_rwn     = 1'b0;
                                w_mem_data_in = cmd_wdata;
                            end
                        endcase
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    w_mem_start = 1'b0;
                    w_state     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    if (r_cmd == CMD_POP || r_cmd == CMD_LOAD) begin
                        w_rdata = mem_data_out;
                    end
                    if (r_cmd == CMD_PUSH) begin
                        w_sp = r_sp + LP_WORD;
                    end else if (r_cmd == CMD_POP) begin
                        w_sp = r_sp - LP_WORD;
                    end
                    w_done  = 1'b1;
                    w_state = S_FIN;
                end
            end
            S_FIN: begin
                // Error path enters FIN with done low and raises it here.
                if (r_done) begin
                    w_busy  = 1'b0;
                    w_err   = 1'b0;
                    w_state = S_IDLE;
                end else begin
                    w_done = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign rdata       = r_rdata;
    assign sp          = r_sp;
    assign mem_start   = r_mem_start;
    assign mem_rwn     = r_mem_rwn;
    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Bench for stack_mem_ctrl: byte-array memory responder with address-dependent
// latency, a vector table of commands and hand-written corner sequences.
module tb_stack_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        busy, done, err;
    logic [31:0] rdata, sp;
    logic        mem_start, mem_rwn;
    logic [31:0] mem_address, mem_data_in;
    logic        mem_ready;
    logic [31:0] mem_data_out;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    stack_mem_ctrl #(.STACK_BASE(192), .STACK_LIMIT(256)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata), .sp(sp),
        .mem_start(mem_start), .mem_rwn(mem_rwn), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_ready(mem_ready), .mem_data_out(mem_data_out)
    );

    // Memory responder: accepts on start&ready, drops ready, completes after 1+k cycles.
    logic [7:0]  mem [0:511];
    logic        m_busy;
    logic        m_rwn;
    logic [31:0] m_addr, m_wdata;
    int          m_cnt;
    logic [8:0]  ma;
    assign ma = m_addr[8:0];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            for (int i = 132; i < 136; i++) mem[i] <= 8'h11;
            mem[140] <= 8'h12; mem[141] <= 8'h34; mem[142] <= 8'h56;
            mem[143] <= 8'hAD; mem[144] <= 8'h78;
            mem_ready    <= 1'b1;
            mem_data_out <= 32'd0;
            m_busy  <= 1'b0;
            m_rwn   <= 1'b1;
            m_addr  <= 32'd0;
            m_wdata <= 32'd0;
            m_cnt   <= 0;
        end else if (!m_busy) begin
            if (mem_start && mem_ready) begin
                m_busy    <= 1'b1;
                mem_ready <= 1'b0;
                m_addr    <= mem_address;
                m_rwn     <= mem_rwn;
                m_wdata   <= mem_data_in;
                m_cnt     <= int'(mem_address[1:0]);
            end
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end else begin
            m_busy    <= 1'b0;
            mem_ready <= 1'b1;
            if (m_rwn) begin
                mem_data_out <= {mem[ma + 9'd3], mem[ma + 9'd2], mem[ma + 9'd1], mem[ma]};
            end else begin
                mem[ma]         <= m_wdata[7:0];
                mem[ma + 9'd1]  <= m_wdata[15:8];
                mem[ma + 9'd2]  <= m_wdata[23:16];
                mem[ma + 9'd3]  <= m_wdata[31:24];
            end
        end
    end

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_sp;
        int          exp_lat;
        logic        exp_start;
        logic        exp_rwn;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic [1:0] c, input logic [31:0] a, input logic [31:0] w,
                                input logic [31:0] rd, input logic e, input logic [31:0] s,
                                input int lat, input logic st, input logic rwn, input logic [31:0] ma_e);
        vec_t v;
        v.cmd = c; v.addr = a; v.wdata = w; v.exp_rdata = rd; v.exp_err = e; v.exp_sp = s;
        v.exp_lat = lat; v.exp_start = st; v.exp_rwn = rwn; v.exp_maddr = ma_e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_sp"}, sp, 32'd192);
        chk({tag, "_start"}, 32'(mem_start), 32'd0);
        chk({tag, "_rwn"}, 32'(mem_rwn), 32'd1);
        chk({tag, "_maddr"}, mem_address, 32'd0);
        chk({tag, "_mdin"}, mem_data_in, 32'd0);
    endtask

    // Issues one command; lat = n such that done is high after edge E+n.
    task automatic run_cmd(input logic [1:0] c, input logic [31:0] a, input logic [31:0] w,
                           input bit hold, output int lat, output bit saw,
                           output logic [31:0] saddr, output logic srwn, output bit stable,
                           output logic busy0, output logic d_err, output logic [31:0] d_rdata,
                           output logic [31:0] d_sp);
        @(negedge clk);
        cmd_valid = 1'b1; cmd = c; cmd_addr = a; cmd_wdata = w;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        saw = 1'b0; saddr = 32'd0; srwn = 1'b0; stable = 1'b1; busy0 = 1'b0;
        d_err = 1'bx; d_rdata = 32'hx; d_sp = 32'hx; lat = 60;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (n == 0) busy0 = busy;
            if (mem_start && !saw) begin
                saddr = mem_address; srwn = mem_rwn; saw = 1'b1;
            end
            if (saw && mem_address !== saddr) stable = 1'b0;
            if (done) begin
                lat = n; d_err = err; d_rdata = rdata; d_sp = sp;
                break;
            end
            if (hold) begin
                cmd = cmd + 2'd1; cmd_addr = $urandom; cmd_wdata = $urandom;
            end
        end
        cmd_valid = 1'b0;
        if (lat == 60) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    int          lat;
    bit          saw, stable, seen_done;
    logic [31:0] saddr, d_rdata, d_sp;
    logic        srwn, busy0, d_err;

    initial begin
        vecs[0]  = mk(2'b10, 32'd132, 32'd0,         32'h11111111, 1'b0, 32'd192, 3, 1'b1, 1'b1, 32'd132);
        vecs[1]  = mk(2'b10, 32'd140, 32'd0,         32'hAD563412, 1'b0, 32'd192, 3, 1'b1, 1'b1, 32'd140);
        vecs[2]  = mk(2'b10, 32'd141, 32'd0,         32'h78AD5634, 1'b0, 32'd192, 4, 1'b1, 1'b1, 32'd141);
        vecs[3]  = mk(2'b00, 32'd0,   32'hDEADBEEF,  32'h78AD5634, 1'b0, 32'd196, 3, 1'b1, 1'b0, 32'd192);
        vecs[4]  = mk(2'b00, 32'd999, 32'h00000005,  32'h78AD5634, 1'b0, 32'd200, 3, 1'b1, 1'b0, 32'd196);
        vecs[5]  = mk(2'b01, 32'd0,   32'd0,         32'h00000005, 1'b0, 32'd196, 3, 1'b1, 1'b1, 32'd196);
        vecs[6]  = mk(2'b01, 32'd0,   32'd0,         32'hDEADBEEF, 1'b0, 32'd192, 3, 1'b1, 1'b1, 32'd192);
        vecs[7]  = mk(2'b01, 32'd0,   32'd0,         32'hDEADBEEF, 1'b1, 32'd192, 1, 1'b0, 1'b0, 32'd0);
        vecs[8]  = mk(2'b11, 32'd148, 32'h01020304,  32'hDEADBEEF, 1'b0, 32'd192, 3, 1'b1, 1'b0, 32'd148);
        vecs[9]  = mk(2'b10, 32'd148, 32'd0,         32'h01020304, 1'b0, 32'd192, 3, 1'b1, 1'b1, 32'd148);
        vecs[10] = mk(2'b11, 32'd150, 32'hCAFEF00D,  32'h01020304, 1'b0, 32'd192, 5, 1'b1, 1'b0, 32'd150);
        vecs[11] = mk(2'b10, 32'd150, 32'd0,         32'hCAFEF00D, 1'b0, 32'd192, 5, 1'b1, 1'b1, 32'd150);

        reset = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; cmd_addr = 32'd0; cmd_wdata = 32'd0;
        repeat (2) @(negedge clk);
        check_reset("por");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_cmd(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, 1'b0, lat, saw, saddr, srwn,
                    stable, busy0, d_err, d_rdata, d_sp);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_busy", i), 32'(busy0), 32'd1);
            chk($sformatf("v%0d_err", i), 32'(d_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_rdata", i), d_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_sp", i), d_sp, vecs[i].exp_sp);
            chk($sformatf("v%0d_start", i), 32'(saw), 32'(vecs[i].exp_start));
            if (vecs[i].exp_start) begin
                chk($sformatf("v%0d_rwn", i), 32'(srwn), 32'(vecs[i].exp_rwn));
                chk($sformatf("v%0d_maddr", i), saddr, vecs[i].exp_maddr);
                chk($sformatf("v%0d_stable", i), 32'(stable), 32'd1);
            end
            chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
        end

        // Fill the stack to the limit, then one more PUSH must overflow.
        for (int k = 0; k < 16; k++) begin
            run_cmd(2'b00, 32'd0, 32'h10000000 + 32'(k), 1'b0, lat, saw, saddr, srwn,
                    stable, busy0, d_err, d_rdata, d_sp);
            chk($sformatf("fill%0d_addr", k), saddr, 32'd192 + 32'(4 * k));
        end
        chk("full_sp", sp, 32'd256);
        run_cmd(2'b00, 32'd0, 32'hBAD0BAD0, 1'b0, lat, saw, saddr, srwn,
                stable, busy0, d_err, d_rdata, d_sp);
        chk("ovf_err", 32'(d_err), 32'd1);
        chk("ovf_lat", 32'(lat), 32'd1);
        chk("ovf_start", 32'(saw), 32'd0);
        chk("ovf_sp", d_sp, 32'd256);
        chk("ovf_mem", {mem[255], mem[254], mem[253], mem[252]}, 32'h1000000F);

        // cmd_valid held high with changing operands while busy.
        run_cmd(2'b10, 32'd132, 32'd0, 1'b1, lat, saw, saddr, srwn,
                stable, busy0, d_err, d_rdata, d_sp);
        chk("hold_lat", 32'(lat), 32'd3);
        chk("hold_rdata", d_rdata, 32'h11111111);
        chk("hold_sp", d_sp, 32'd256);
        chk("hold_maddr", saddr, 32'd132);
        chk("hold_stable", 32'(stable), 32'd1);
        repeat (3) @(negedge clk);
        chk("hold_no_extra_busy", 32'(busy), 32'd0);
        chk("hold_no_extra_start", 32'(mem_start), 32'd0);
        chk("hold_sp_after", sp, 32'd256);

        // Reset asserted while the controller waits on memory.
        @(negedge clk);
        cmd_valid = 1'b1; cmd = 2'b10; cmd_addr = 32'd141;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_start", 32'(mem_start), 32'd0);
        reset = 1'b1;
        #1;
        check_reset("midrst");
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        reset = 1'b0;
        @(negedge clk);
        if (done) seen_done = 1'b1;
        chk("midrst_no_done", 32'(seen_done), 32'd0);

        run_cmd(2'b10, 32'd132, 32'd0, 1'b0, lat, saw, saddr, srwn,
                stable, busy0, d_err, d_rdata, d_sp);
        chk("post_rst_lat", 32'(lat), 32'd3);
        chk("post_rst_rdata", d_rdata, 32'h11111111);
        chk("post_rst_err", 32'(d_err), 32'd0);
        chk("post_rst_sp", d_sp, 32'd192);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/stack_mem_ctrl.md
Name: stack_mem_ctrl

Overview:
Bus initiator that drives the byte-addressed 32-bit memory responder's start/ready/rwn handshake on behalf of the JVM datapath. It executes PUSH/POP on the operand stack, which it owns via an internal stack pointer, and LOAD/STORE at arbitrary addresses for locals and constants. It sits between the execute FSM and the memory. One command is outstanding at a time; completion is signalled with a one-cycle done pulse.

Parameters:
STACK_BASE, 192, byte address of the first stack word; also the empty-stack SP value.
STACK_LIMIT, 256, exclusive upper byte bound of the stack; SP==STACK_LIMIT means full.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request; sampled only while busy=0
cmd  input  2  00 PUSH, 01 POP, 10 LOAD, 11 STORE
cmd_addr  input  32  byte address for LOAD/STORE; ignored for PUSH/POP
cmd_wdata  input  32  write data for PUSH/STORE
busy  output  1  high from the edge a command is accepted until done is asserted
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = overflow or underflow, no memory access made
rdata  output  32  POP/LOAD result; held until the next POP/LOAD completes
sp  output  32  stack pointer; points to the next free word
mem_start  output  1  request to memory
mem_rwn  output  1  1 = read, 0 = write
mem_address  output  32  memory byte address
mem_data_in  output  32  memory write data
mem_ready  input  1  memory idle/complete indicator
mem_data_out  input  32  memory read data; little-endian, valid when mem_ready returns high

Behaviour:
- Reset (async, any state): state IDLE, busy=0, done=0, err=0, rdata=0, sp=STACK_BASE, mem_start=0, mem_rwn=1, mem_address=0, mem_data_in=0. Reset in mid-transaction abandons the transaction with no done pulse. Memory shares this reset.
- States: IDLE, REQ, WAIT, FIN. All outputs are registered.
- IDLE: on cmd_valid=1, latch the command and set busy=1.
  - PUSH with sp==STACK_LIMIT, or POP with sp==STACK_BASE: go to FIN with err=1. No memory access is made and sp is unchanged.
  - Otherwise go to REQ with mem_start=1. Address is PUSH: sp; POP: sp-4; LOAD/STORE: cmd_addr. mem_rwn=1 for POP/LOAD, 0 for PUSH/STORE. mem_data_in=cmd_wdata for writes.
- REQ: hold mem_start high until an edge samples mem_ready=1. At that edge, drop mem_start and go to WAIT. Address and data remain stable until done.
- WAIT: mem_ready is 0 on entry, because the memory drops ready the cycle after acceptance. At the first edge sampling mem_ready=1:
  - capture mem_data_out into rdata (reads only);
  - update sp: PUSH sp+4, POP sp-4;
  - go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE with busy=0 and err=0.
- Latency: with cmd sampled at edge E and the memory idle, done is high in the cycle after edge E+3+k, where k=mem_address[1:0]. The error path gives done after edge E+1.
- cmd_valid while busy is ignored; it is neither queued nor able to corrupt latched operands.
- Misaligned LOAD/STORE are legal. They take k extra cycles, and the memory handles the byte assembly.
- sp arithmetic is 32-bit unsigned. It never leaves [STACK_BASE, STACK_LIMIT] because of the bound checks.
- mem_start is never asserted outside REQ.

Test Plan:
- Reset, then LOAD addr 132 -> mem_rwn=1, mem_address=132, done after E+3, rdata=0x11111111, err=0, sp=192.
- LOAD addr 140 -> rdata=0xAD563412. Then LOAD addr 141 (k=1) -> done after E+4, exactly one cycle later than the aligned case.
- PUSH 0xDEADBEEF then PUSH 0x00000005 -> writes at 192 and 196, sp=200. POP -> read at 196, rdata=5, sp=196. POP -> rdata=0xDEADBEEF, sp=192.
- POP at sp=192 -> done+err after E+1, mem_start never high, sp=192. Push 16 words -> sp=256; a 17th PUSH -> err=1, memory bytes 252..255 unchanged.
- Hold cmd_valid=1 with varying cmd while busy -> only the first command executes. STORE 0x01020304 to 148 then LOAD 148 -> rdata=0x01020304.
- Assert reset while in WAIT -> all outputs take reset values immediately with no done pulse. Next LOAD 132 completes normally.
